reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Producer-side companion to the ID-stage forwarding logic. Tracks the
//  architectural registers whose writer is a long-latency op (load, mul/div)
//  still in flight. Raises a stall in ID while any source or destination of
//  the ID instruction is still owed a result.
//  Fixed-latency ALU results stay with the EXE/MEM forwarding paths; this
//  block does not track them.
// PARAMETERS
//  MAX_OUT  4  max long-latency writes in flight (1..31)
//  CNT_W    3  width of outstanding count; must hold MAX_OUT
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  id_rs1_addr    in   5      ID source 1 register
//  id_rs1_used    in   1      instruction reads rs1
//  id_rs2_addr    in   5      ID source 2 register
//  id_rs2_used    in   1      instruction reads rs2
//  id_rd_addr     in   5      ID destination register
//  id_RegWrite    in   1      instruction writes rd
//  id_long        in   1      writer is long-latency (result arrives via wb_*)
//  id_fire        in   1      instruction leaves ID this cycle (not stalled/flushed)
//  wb_valid       in   1      long-latency result written back this cycle
//  wb_rd_addr     in   5      register being written back
//  stall          out  1      hold ID (combinational)
//  pending_vec    out  32     bit i = xi awaiting long-latency result
//  outstanding    out  CNT_W  number of pending bits set
//  full           out  1      outstanding == MAX_OUT
//  err            out  1      sticky protocol-violation flag
// BEHAVIOUR
//  Reset: pending_vec=0, outstanding=0, full=0, err=0.
//  Reset mid-operation drops all tracking.
//  x0: bit 0 never set; issue and completion to x0 are ignored.
//  clr_i = wb_valid && wb_rd_addr==i && pending_vec[i]
//  busy_i = pending_vec[i] && !clr_i
//    (same-cycle writeback releases the register; wb data reaches ID over the bypass path)
//  stall = (id_rs1_used && busy(rs1)) || (id_rs2_used && busy(rs2))
//        || (id_RegWrite && rd!=0 && busy(rd))              [WAW]
//        || (id_RegWrite && id_long && rd!=0 && full && !any_clr)
//  set = id_fire && id_RegWrite && id_long && rd!=0 && !stall
//  Next state, latency 1 cycle:
//    pending_vec[rd] <= 1 on set
//    pending_vec[wb_rd] <= 0 on clr
//    Set and clr on the same register in the same cycle: set wins (new owner).
//  outstanding next = outstanding + set - (any clr), saturating at 0 and MAX_OUT.
//  Outputs full and outstanding are registered-state derived, with no comb path from inputs.
//  err <= 1 when any of these occurs; it holds until rst:
//    (a) wb_valid, wb_rd!=0, pending bit clear (unexpected completion; state unchanged)
//    (b) id_fire while stall=1 (fire ignored; no set)
//  stall depends only on current inputs and state. No internal pipelining.
// TESTING
//  1 rst; issue lw x5 (fire,long) -> next cycle pending_vec=0x20, outstanding=1;
//    add x6,x5 in ID -> stall=1
//  2 With x5 pending, wb_valid wb_rd=5 in the same cycle add x6,x5 sits in ID
//    -> stall=0 that cycle; pending_vec=0 next cycle
//  3 Issue long writes to x1..x4 (MAX_OUT=4) -> full=1; long write to x7 stalls;
//    wb x2 that cycle -> stall=0, and next cycle x7 set, x2 clear, outstanding=4
//  4 wb_valid wb_rd=9 with x9 not pending -> err=1 and stays 1;
//    pending_vec and outstanding unchanged
//  5 lw x0 fired -> pending_vec stays 0; lw x8 then lw x8 (WAW) -> second stalls
//    until wb x8
//  6 3 regs pending, assert rst one cycle -> all outputs 0 next cycle,
//    and a following wb to one of those regs sets err

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency writers (loads, mul/div).
// Tracks pending destination registers and stalls ID on RAW/WAW hazards or capacity.
module reg_scoreboard #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_RegWrite,
    input  logic             id_long,
    input  logic             id_fire,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd_addr,
    output logic             stall,
    output logic [31:0]      pending_vec,
    output logic [CNT_W-1:0] outstanding,
    output logic             full,
    output logic             err
);

    localparam int unsigned SW = CNT_W + 1;

    logic          wb_hit;
    logic          any_clr;
    logic          unexp_wb;
    logic          busy_rs1;
    logic          busy_rs2;
    logic          busy_rd;
    logic          rd_nz;
    logic          set;
    logic [31:0]   pending_next;
    logic [SW-1:0] cnt_next;

    assign wb_hit   = wb_valid && (wb_rd_addr != 5'd0);
    assign any_clr  = wb_hit && pending_vec[wb_rd_addr];
    assign unexp_wb = wb_hit && !pending_vec[wb_rd_addr];
    assign rd_nz    = (id_rd_addr != 5'd0);

    // A register written back this cycle is no longer busy; data arrives via bypass.
    assign busy_rs1 = pending_vec[id_rs1_addr] && !(any_clr && (wb_rd_addr == id_rs1_addr));
    assign busy_rs2 = pending_vec[id_rs2_addr] && !(any_clr && (wb_rd_addr == id_rs2_addr));
    assign busy_rd  = pending_vec[id_rd_addr]  && !(any_clr && (wb_rd_addr == id_rd_addr));

    assign stall = (id_rs1_used && busy_rs1)
                || (id_rs2_used && busy_rs2)
                || (id_RegWrite && rd_nz && busy_rd)
                || (id_RegWrite && id_long && rd_nz && full && !any_clr);

    assign set = id_fire && id_RegWrite && id_long && rd_nz && !stall;

    // Clear first, then set, so a same-cycle reissue keeps the bit (new owner).
    always_comb begin
        pending_next = pending_vec;
        if (any_clr) begin
            pending_next[wb_rd_addr] = 1'b0;
        end
        if (set) begin
            pending_next[id_rd_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = {1'b0, outstanding} + SW'(set);
        if (any_clr && (cnt_next != '0)) begin
            cnt_next = cnt_next - SW'(1);
        end
        if (cnt_next > SW'(MAX_OUT)) begin
            cnt_next = SW'(MAX_OUT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_vec <= '0;
            outstanding <= '0;
            full        <= 1'b0;
            err         <= 1'b0;
        end else begin
            pending_vec <= pending_next;
            outstanding <= cnt_next[CNT_W-1:0];
            full        <= (cnt_next == SW'(MAX_OUT));
            err         <= err || unexp_wb || (id_fire && stall);
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: stall checked each cycle,
// expected next state queued at drive time and compared after the clock edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, wb_rd_addr;
    logic        id_rs1_used, id_rs2_used, id_RegWrite, id_long, id_fire, wb_valid;
    logic        stall, full, err;
    logic [31:0] pending_vec;
    logic [2:0]  outstanding;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        lng;
        logic        fire;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        stall;
        logic [31:0] pv;
        logic [2:0]  cnt;
        logic        err;
    } step_t;

    step_t sbq[$];

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_OUT(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1_addr (id_rs1_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_addr (id_rs2_addr),
        .id_rs2_used (id_rs2_used),
        .id_rd_addr  (id_rd_addr),
        .id_RegWrite (id_RegWrite),
        .id_long     (id_long),
        .id_fire     (id_fire),
        .wb_valid    (wb_valid),
        .wb_rd_addr  (wb_rd_addr),
        .stall       (stall),
        .pending_vec (pending_vec),
        .outstanding (outstanding),
        .full        (full),
        .err         (err)
    );

    function automatic step_t mk(input logic r, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic lng, input logic fire,
                                 input logic wbv, input logic [4:0] wbrd, input logic st,
                                 input logic [31:0] pv, input logic [2:0] cnt, input logic e);
        step_t s;
        s.rst = r; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd;
        s.rw = rw; s.lng = lng; s.fire = fire; s.wbv = wbv; s.wbrd = wbrd;
        s.stall = st; s.pv = pv; s.cnt = cnt; s.err = e;
        return s;
    endfunction

    task automatic apply(input step_t s);
        rst = s.rst; id_rs1_addr = s.rs1; id_rs1_used = s.u1; id_rs2_addr = s.rs2;
        id_rs2_used = s.u2; id_rd_addr = s.rd; id_RegWrite = s.rw; id_long = s.lng;
        id_fire = s.fire; wb_valid = s.wbv; wb_rd_addr = s.wbrd;
    endtask

    task automatic test_reset();
        step_t s[$];
        step_t e;
        s.push_back(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        s.push_back(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL reset[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL reset[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_issue_stall();
        step_t s[$];
        step_t e;
        s.push_back(mk(0, 0,0, 0,0, 5,1,1,1, 0,0, 0, 32'h20, 1, 0));
        s.push_back(mk(0, 5,1, 0,0, 6,1,0,0, 0,0, 1, 32'h20, 1, 0));
        s.push_back(mk(0, 5,1, 0,0, 6,1,0,1, 1,5, 0, 32'h0,  0, 0));
        s.push_back(mk(0, 0,0, 0,0, 5,1,1,1, 0,0, 0, 32'h20, 1, 0));
        s.push_back(mk(0, 0,1, 5,1, 6,1,0,0, 0,0, 1, 32'h20, 1, 0));
        s.push_back(mk(0, 5,0, 0,0, 0,0,0,0, 0,0, 0, 32'h20, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,5, 0, 32'h0,  0, 0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL issue[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL issue[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_full();
        step_t s[$];
        step_t e;
        s.push_back(mk(0, 0,0, 0,0, 1,1,1,1, 0,0, 0, 32'h02, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 2,1,1,1, 0,0, 0, 32'h06, 2, 0));
        s.push_back(mk(0, 0,0, 0,0, 3,1,1,1, 0,0, 0, 32'h0E, 3, 0));
        s.push_back(mk(0, 0,0, 0,0, 4,1,1,1, 0,0, 0, 32'h1E, 4, 0));
        s.push_back(mk(0, 0,0, 0,0, 7,1,1,0, 0,0, 1, 32'h1E, 4, 0));
        s.push_back(mk(0, 0,0, 0,0, 7,1,1,1, 1,2, 0, 32'h9A, 4, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,1, 0, 32'h98, 3, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,3, 0, 32'h90, 2, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,4, 0, 32'h80, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,7, 0, 32'h00, 0, 0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL full[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL full[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_x0_waw();
        step_t s[$];
        step_t e;
        s.push_back(mk(0, 0,0, 0,0, 0,1,1,1, 0,0, 0, 32'h000, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,0, 0, 32'h000, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 8,1,1,1, 0,0, 0, 32'h100, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 8,1,1,0, 0,0, 1, 32'h100, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 8,1,1,0, 0,0, 1, 32'h100, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 8,1,1,1, 1,8, 0, 32'h100, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,8, 0, 32'h000, 0, 0));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL x0_waw[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL x0_waw[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_fire_stall();
        step_t s[$];
        step_t e;
        s.push_back(mk(0, 0,0, 0,0, 5,1,1,1, 0,0, 0, 32'h20, 1, 0));
        s.push_back(mk(0, 5,1, 0,0, 6,1,1,1, 0,0, 1, 32'h20, 1, 1));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,5, 0, 32'h00, 0, 1));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL fire_stall[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL fire_stall[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_unexpected_wb();
        step_t s[$];
        step_t e;
        s.push_back(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 3,1,1,1, 0,0, 0, 32'h8, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,9, 0, 32'h8, 1, 1));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h8, 1, 1));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,3, 0, 32'h0, 0, 1));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL unexp_wb[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL unexp_wb[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        step_t e;
        s.push_back(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 1,1,1,1, 0,0, 0, 32'h2, 1, 0));
        s.push_back(mk(0, 0,0, 0,0, 2,1,1,1, 0,0, 0, 32'h6, 2, 0));
        s.push_back(mk(0, 0,0, 0,0, 3,1,1,1, 0,0, 0, 32'hE, 3, 0));
        s.push_back(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        s.push_back(mk(0, 0,0, 0,0, 0,0,0,0, 1,2, 0, 32'h0, 0, 1));
        foreach (s[i]) begin
            @(negedge clk); apply(s[i]); #1;
            checks++;
            if (stall !== s[i].stall) begin
                errors++; $display("FAIL reset_mid[%0d] stall got %b want %b", i, stall, s[i].stall);
            end
            sbq.push_back(s[i]);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({pending_vec, outstanding, full, err} !== {e.pv, e.cnt, e.cnt == 3'd4, e.err}) begin
                errors++;
                $display("FAIL reset_mid[%0d] state got pv=%h cnt=%0d full=%b err=%b want pv=%h cnt=%0d full=%b err=%b",
                         i, pending_vec, outstanding, full, err, e.pv, e.cnt, e.cnt == 3'd4, e.err);
            end
        end
    endtask

    initial begin
        apply(mk(1, 0,0, 0,0, 0,0,0,0, 0,0, 0, 32'h0, 0, 0));
        test_reset();
        test_issue_stall();
        test_full();
        test_x0_waw();
        test_fire_stall();
        test_unexpected_wb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
